// File: rtl/fetch_ctrl_pkg.sv
// Shared front-end definitions: fetch FSM state encoding (decoded by trace/debug
// logic through fetch_state) and the default sequential instruction size.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    F_BOOT       = 2'd0,
    F_RUN        = 2'd1,
    F_MISS       = 2'd2,
    F_MISS_FLUSH = 2'd3
  } FetchState_t;

  localparam int INST_BYTES_DEF = 4;
  localparam int PERF_W         = 32;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Single saturating event counter; counts every cycle inc_ is low and sticks
// at all-ones.
module fetch_perf_cnt
  import fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_,
  input  logic              inc_,
  output logic [PERF_W-1:0] count
);

  logic [PERF_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      count_q <= '0;
    end else if (!inc_ && (count_q != {PERF_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC and the I-cache enable, arbitrating
// flush / miss / decode-busy / predictor redirects. FETCH_CTRL_PERF_EN adds perf counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              ADDR       = 32,
  parameter logic [ADDR-1:0] RESET_PC   = '0,
  parameter int              INST_BYTES = INST_BYTES_DEF
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            dec_busy_,
  input  logic            ic_miss_,
  input  logic            ic_refill_done_,
  input  logic            pred_taken_,
  input  logic [ADDR-1:0] pred_target,
  input  logic            flush_,
  input  logic [ADDR-1:0] flush_pc,
  output logic [ADDR-1:0] fetch_pc,
  output logic            fetch_e_,
  output logic            dec_kill_,
  output logic [1:0]      fetch_state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_miss_cyc,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_redirects
`endif
);

  localparam logic [ADDR-1:0] PC_INC = ADDR'(INST_BYTES);

  FetchState_t     state_q;
  logic [ADDR-1:0] pc_q;
  logic [ADDR-1:0] redir_q;
  logic            fetch_e_q;

  // All active-low controls: 0 means asserted. Arms are in priority order.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= F_BOOT;
      pc_q      <= RESET_PC;
      redir_q   <= '0;
      fetch_e_q <= 1'b1;
    end else begin
      case (state_q)
        F_BOOT: begin
          state_q   <= F_RUN;
          fetch_e_q <= 1'b0;
        end
        F_RUN: begin
          if (!flush_) begin
            pc_q <= flush_pc;
          end else if (!ic_miss_) begin
            state_q   <= F_MISS;
            fetch_e_q <= 1'b1;
          end else if (!dec_busy_) begin
            pc_q <= pc_q;
          end else if (!pred_taken_) begin
            pc_q <= pred_target;
          end else begin
            pc_q <= pc_q + PC_INC;
          end
        end
        F_MISS: begin
          if (!ic_refill_done_) begin
            state_q   <= F_RUN;
            fetch_e_q <= 1'b0;
            if (!flush_) pc_q <= flush_pc;
          end else if (!flush_) begin
            state_q <= F_MISS_FLUSH;
            redir_q <= flush_pc;
          end
        end
        F_MISS_FLUSH: begin
          // Refill is never aborted; the newest flush target wins at completion.
          if (!ic_refill_done_) begin
            state_q   <= F_RUN;
            fetch_e_q <= 1'b0;
            pc_q      <= (!flush_) ? flush_pc : redir_q;
          end else if (!flush_) begin
            redir_q <= flush_pc;
          end
        end
        default: begin
          state_q   <= F_BOOT;
          fetch_e_q <= 1'b1;
        end
      endcase
    end
  end

  assign fetch_pc    = pc_q;
  assign fetch_e_    = fetch_e_q;
  assign fetch_state = state_q;
  assign dec_kill_   = ~(~flush_ | (~ic_miss_ & (state_q == F_RUN)));

`ifdef FETCH_CTRL_PERF_EN
  logic miss_inc_;
  logic stall_inc_;
  logic redir_inc_;

  assign miss_inc_  = ~((state_q == F_MISS) | (state_q == F_MISS_FLUSH));
  assign stall_inc_ = ~((state_q == F_RUN) & ~dec_busy_);
  // A flush during boot is not accepted, so it is not counted.
  assign redir_inc_ = ~((state_q != F_BOOT) & ~flush_);

  fetch_perf_cnt u_miss_cnt  (.clk(clk), .reset_(reset_), .inc_(miss_inc_),  .count(perf_miss_cyc));
  fetch_perf_cnt u_stall_cnt (.clk(clk), .reset_(reset_), .inc_(stall_inc_), .count(perf_stall_cyc));
  fetch_perf_cnt u_redir_cnt (.clk(clk), .reset_(reset_), .inc_(redir_inc_), .count(perf_redirects));
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then randomized traffic, checked
// against a flag-based behavioural model. Perf checks under FETCH_CTRL_PERF_EN.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic        A = 1'b0;  // asserted (active low)
  localparam logic        N = 1'b1;  // idle

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_;
  logic        dec_busy_, ic_miss_, ic_refill_done_, pred_taken_, flush_;
  logic [31:0] pred_target, flush_pc;
  logic [31:0] fetch_pc;
  logic        fetch_e_, dec_kill_;
  logic [1:0]  fetch_state;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_miss_cyc, perf_stall_cyc, perf_redirects;
`endif

  fetch_ctrl #(.ADDR(32), .RESET_PC(RST_PC), .INST_BYTES(4)) dut (
    .clk(clk), .reset_(reset_), .dec_busy_(dec_busy_), .ic_miss_(ic_miss_),
    .ic_refill_done_(ic_refill_done_), .pred_taken_(pred_taken_),
    .pred_target(pred_target), .flush_(flush_), .flush_pc(flush_pc),
    .fetch_pc(fetch_pc), .fetch_e_(fetch_e_), .dec_kill_(dec_kill_),
    .fetch_state(fetch_state)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_miss_cyc(perf_miss_cyc), .perf_stall_cyc(perf_stall_cyc),
    .perf_redirects(perf_redirects)
`endif
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  bit          m_booted, m_in_miss, m_pend;
  logic [31:0] m_pc, m_pend_pc;
  longint      m_miss_cnt, m_stall_cnt, m_redir_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic model_reset();
    m_booted = 0; m_in_miss = 0; m_pend = 0;
    m_pc = RST_PC; m_pend_pc = '0;
    m_miss_cnt = 0; m_stall_cnt = 0; m_redir_cnt = 0;
    exp_q.delete();
  endtask

  // One clock edge of the specification's rules, using the inputs now driven.
  task automatic model_edge();
    if (m_in_miss) m_miss_cnt++;
    if (m_booted && !m_in_miss && !dec_busy_) m_stall_cnt++;
    if (m_booted && !flush_) m_redir_cnt++;
    if (!m_booted) begin
      m_booted = 1;
    end else if (!m_in_miss) begin
      if (!flush_)            m_pc = flush_pc;
      else if (!ic_miss_)     m_in_miss = 1;
      else if (!dec_busy_)    m_pc = m_pc;
      else if (!pred_taken_)  m_pc = pred_target;
      else                    m_pc = m_pc + 32'd4;
    end else if (!ic_refill_done_) begin
      if (!flush_)     m_pc = flush_pc;
      else if (m_pend) m_pc = m_pend_pc;
      m_in_miss = 0;
      m_pend    = 0;
    end else if (!flush_) begin
      m_pend    = 1;
      m_pend_pc = flush_pc;
    end
    exp_q.push_back(m_pc);
  endtask

  function automatic logic [31:0] exp_state();
    if (!m_booted) return 32'd0;
    if (m_in_miss) return m_pend ? 32'd3 : 32'd2;
    return 32'd1;
  endfunction

  task automatic check_outputs();
    chk("fetch_pc", fetch_pc, exp_q.pop_front());
    chk("fetch_e_", {31'd0, fetch_e_}, {31'd0, !(m_booted && !m_in_miss)});
    chk("fetch_state", {30'd0, fetch_state}, exp_state());
`ifdef FETCH_CTRL_PERF_EN
    chk("perf_miss_cyc", perf_miss_cyc, sat(m_miss_cnt));
    chk("perf_stall_cyc", perf_stall_cyc, sat(m_stall_cnt));
    chk("perf_redirects", perf_redirects, sat(m_redir_cnt));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    dec_busy_ = N; ic_miss_ = N; ic_refill_done_ = N; pred_taken_ = N; flush_ = N;
    pred_target = '0; flush_pc = '0;
  endtask

  task automatic step(input logic busy, input logic miss, input logic refill,
                      input logic pred, input logic [31:0] tgt,
                      input logic flush, input logic [31:0] fpc);
    logic exp_kill;
    @(negedge clk);
    dec_busy_ = busy; ic_miss_ = miss; ic_refill_done_ = refill;
    pred_taken_ = pred; pred_target = tgt; flush_ = flush; flush_pc = fpc;
    #1;
    exp_kill = !(!flush_ || (!ic_miss_ && m_booted && !m_in_miss));
    chk("dec_kill_", {31'd0, dec_kill_}, {31'd0, exp_kill});
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(N, N, N, N, '0, N, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    set_idle();
    reset_ = 1'b0;
    model_reset();
    #1;
    chk("rst_fetch_pc", fetch_pc, RST_PC);
    chk("rst_fetch_e_", {31'd0, fetch_e_}, 32'd1);
    chk("rst_state", {30'd0, fetch_state}, 32'd0);
    chk("rst_dec_kill_", {31'd0, dec_kill_}, 32'd1);
    @(posedge clk);
    #2;
    reset_ = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_ = 1'b0;
    set_idle();
    model_reset();

    // Boot and sequential fetch, then a zero-bubble predicted redirect at 0x108.
    do_reset();
    idle(3);                                   // 100, 104, 108
    step(N, N, N, A, 32'h200, N, '0);          // -> 200
    idle(1);                                   // -> 204

    // Miss at 0x104, refill five cycles later, refetch 0x104.
    do_reset();
    idle(2);                                   // 100, 104
    step(N, A, N, N, '0, N, '0);               // miss
    idle(4);
    step(N, N, A, N, '0, N, '0);               // refill done
    chk("refetch_pc", fetch_pc, 32'h104);

    // Two flushes during a miss: newest wins at refill.
    step(N, A, N, N, '0, N, '0);
    step(N, N, N, N, '0, A, 32'h400);
    idle(1);
    step(N, N, N, N, '0, A, 32'h500);
    step(N, N, A, N, '0, N, '0);
    chk("newest_flush_pc", fetch_pc, 32'h500);

    // Flush coincident with refill done in F_MISS.
    step(N, A, N, N, '0, N, '0);
    step(N, N, A, N, '0, A, 32'h640);

    // Flush beats busy and predictor at 0x10C.
    do_reset();
    idle(4);                                   // 100 .. 10C
    step(A, N, N, A, 32'h200, A, 32'h700);
    chk("flush_prio_pc", fetch_pc, 32'h700);

    // PC wrap-around.
    step(N, N, N, N, '0, A, 32'hFFFF_FFFC);
    idle(2);

`ifdef FETCH_CTRL_PERF_EN
    // 3 miss cycles, 2 busy cycles, 1 flush.
    do_reset();
    idle(1);
    step(N, A, N, N, '0, N, '0);
    idle(2);
    step(N, N, A, N, '0, N, '0);
    step(A, N, N, N, '0, N, '0);
    step(A, N, N, N, '0, N, '0);
    step(N, N, N, N, '0, A, 32'h300);
    chk("perf_miss_total", perf_miss_cyc, 32'd3);
    chk("perf_stall_total", perf_stall_cyc, 32'd2);
    chk("perf_redir_total", perf_redirects, 32'd1);
`endif

    // Randomized traffic with one mid-run reset.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 5) != 0),
           logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) != 0),
           $urandom(), logic'($urandom_range(0, 7) != 0), $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
